// File: rtl/ristretto_dec_seq.sv
// ristretto_dec_seq: decode-stage sequencer for the Ristretto core.
// Owns the instruction register and the fetch/execute handshakes.
// CSR-class SYSTEM instructions are split into two micro-steps.
// Decoder-flagged invalid instructions become a trap that holds until flush.
// Optional build macro RISTRETTO_DEC_SEQ_PERF_EN adds the stall and retire counters.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | IR empty, ready to accept from fetch
// ST_ISSUE | IR full, presenting micro-step 0
// ST_STEP1 | IR full, presenting micro-step 1 (CSR ops only)
// ST_TRAP  | invalid instruction seen, waiting for flush
module ristretto_dec_seq #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [DataWidth-1:0] if_instr_i,
    input  logic [AddrWidth-1:0] if_pc_i,
    output logic [DataWidth-1:0] dec_instr_o,
    input  logic [8:0]           dec_addr_i,
    input  logic                 dec_invalid_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [8:0]           ex_urom_addr_o,
    output logic                 ex_ustep_o,
    output logic                 ex_last_o,
    output logic [AddrWidth-1:0] ex_pc_o,
    input  logic                 flush_i,
    output logic                 trap_o,
    output logic [AddrWidth-1:0] trap_pc_o
`ifdef RISTRETTO_DEC_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_instr_cnt_o
`endif
);

    // NOP (ADDI x0,x0,0) keeps the decoder quiet while the IR holds no real work.
    localparam logic [DataWidth-1:0] NopInstr    = DataWidth'(32'h00000013);
    localparam logic [4:0]           ClassSystem = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STEP1,
        ST_TRAP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DataWidth-1:0] ir_q;
    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] trap_pc_q;

    logic in_exec;
    logic two_step;
    logic ex_fire;
    logic accept;

    assign dec_instr_o    = ir_q;
    assign ex_urom_addr_o = dec_addr_i;
    assign ex_pc_o        = pc_q;
    assign trap_pc_o      = trap_pc_q;

    // Handshake and micro-step outputs derived from the current state and decoder.
    always_comb begin
        in_exec    = (state_q == ST_ISSUE) || (state_q == ST_STEP1);
        // ECALL/EBREAK share the SYSTEM class but have funct3 == 0 and stay single-step.
        two_step   = (dec_addr_i[8:4] == ClassSystem) && (ir_q[14:12] != 3'b000);
        ex_valid_o = in_exec && !dec_invalid_i;
        ex_ustep_o = (state_q == ST_STEP1);
        ex_last_o  = (state_q == ST_STEP1) || ((state_q == ST_ISSUE) && !two_step);
        ex_fire    = ex_valid_o && ex_ready_i;
        // Retiring the last micro-op frees the IR in the same cycle for back-to-back issue.
        if_ready_o = !flush_i && ((state_q == ST_IDLE) || (ex_fire && ex_last_o));
        accept     = if_valid_i && if_ready_o;
        trap_o     = !flush_i && (state_q == ST_ISSUE) && dec_invalid_i;
    end

    // Next-state selection; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (dec_invalid_i) begin
                        state_d = ST_TRAP;
                    end else if (ex_ready_i) begin
                        if (two_step)    state_d = ST_STEP1;
                        else if (accept) state_d = ST_ISSUE;
                        else             state_d = ST_IDLE;
                    end
                end
                ST_STEP1: begin
                    if (ex_fire) state_d = accept ? ST_ISSUE : ST_IDLE;
                end
                ST_TRAP: begin
                    state_d = ST_TRAP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Instruction register and its PC; flush parks a NOP in the IR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q <= NopInstr;
            pc_q <= '0;
        end else if (flush_i) begin
            ir_q <= NopInstr;
        end else if (accept) begin
            ir_q <= if_instr_i;
            pc_q <= if_pc_i;
        end
    end

    // Trap PC captured on the trap pulse and held until the pipeline is flushed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        trap_pc_q <= '0;
        else if (flush_i) trap_pc_q <= '0;
        else if (trap_o)  trap_pc_q <= pc_q;
    end

`ifdef RISTRETTO_DEC_SEQ_PERF_EN
    // Stall and retire counters; they wrap and survive flushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_instr_cnt_o <= '0;
        end else begin
            if (ex_valid_o && !ex_ready_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (ex_fire && ex_last_o)      perf_instr_cnt_o <= perf_instr_cnt_o + 32'd1;
        end
    end
`endif

endmodule
